// File: rtl/cpu_fetch_decode_if.sv
// Byte-wide instruction fetch port between the CPU sequencer and program memory.
interface cpu_fetch_decode_if;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/cpu_fetch_decode.sv
// Fetch/decode/sequence controller for the 8-bit CPU: two-byte fetch, decode,
// register-file control, ALU opcode and jump/branch resolution.
module cpu_fetch_decode #(
  parameter logic [7:0]  RESET_PC   = 8'h00,
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  cpu_fetch_decode_if.master        bus,
  input  logic [7:0]                reg_a,
  input  logic [7:0]                alu_result,
  output logic [7:0]                pc,
  output logic [3:0]                rs,
  output logic [3:0]                rt,
  output logic [3:0]                rd,
  output logic [2:0]                alu_op,
  output logic                      rf_we,
  output logic                      rf_oe,
  output logic [7:0]                rf_wdata,
  output logic                      halted,
  output logic                      fault,
  output logic                      illegal
);

  typedef enum logic [2:0] {
    FETCH_HI,
    FETCH_LO,
    DECODE,
    EXEC,
    WB,
    HALTED
  } state_t;

  state_t           state, state_n;
  logic [15:0]      ir;
  logic [CNT_W-1:0] wait_cnt;
  logic             req, req_n;
  logic             fetching, accept, timeout, jump_taken;
  logic [3:0]       op;

  assign op = ir[15:12];

  always_comb begin
    fetching   = (state == FETCH_HI) || (state == FETCH_LO);
    accept     = fetching && req && bus.mem_ack;
    timeout    = fetching && req && !bus.mem_ack &&
                 (wait_cnt == CNT_W'(WAIT_LIMIT - 1));
    jump_taken = (op == 4'h8) || ((op == 4'h9) && (reg_a == '0));
    state_n    = state;
    case (state)
      FETCH_HI: if (timeout) state_n = HALTED;
                else if (accept) state_n = FETCH_LO;
      FETCH_LO: if (timeout) state_n = HALTED;
                else if (accept) state_n = DECODE;
      DECODE:   state_n = EXEC;
      EXEC: begin
        if (op inside {[4'h1:4'h7]}) state_n = WB;
        else if (op == 4'hF)         state_n = HALTED;
        else                         state_n = FETCH_HI;
      end
      WB:       state_n = FETCH_HI;
      HALTED:   state_n = HALTED;
      default:  state_n = FETCH_HI;
    endcase
    // Request is registered so it is low right after reset yet rises on entry to a fetch state.
    req_n = (state_n == FETCH_HI) || (state_n == FETCH_LO);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FETCH_HI;
      req      <= 1'b0;
      pc       <= RESET_PC;
      ir       <= '0;
      wait_cnt <= '0;
      rs       <= '0;
      rt       <= '0;
      rd       <= '0;
      alu_op   <= '0;
      rf_wdata <= '0;
      fault    <= 1'b0;
    end else begin
      state <= state_n;
      req   <= req_n;
      case (state)
        FETCH_HI, FETCH_LO: begin
          if (accept) begin
            if (state == FETCH_HI) ir[15:8] <= bus.mem_rdata;
            else                   ir[7:0]  <= bus.mem_rdata;
            pc       <= pc + 8'd1;
            wait_cnt <= '0;
          end else if (req) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (timeout) fault <= 1'b1;
          end
        end
        DECODE: begin
          rd     <= ir[11:8];
          rt     <= ir[3:0];
          // BEQZ tests the register named in the rd field.
          rs     <= (op == 4'h9) ? ir[11:8] : ir[7:4];
          alu_op <= ir[14:12];
        end
        EXEC: begin
          if (op == 4'h6)      rf_wdata <= ir[7:0];
          else if (op == 4'h7) rf_wdata <= reg_a;
          else                 rf_wdata <= alu_result;
          if (jump_taken) pc <= ir[7:0];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.mem_req  = req;
    bus.mem_addr = pc;
    rf_we        = (state == WB);
    rf_oe        = (state == DECODE) || (state == EXEC);
    halted       = (state == HALTED);
    illegal      = (state == DECODE) && (op inside {[4'hA:4'hE]});
  end

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Scoreboard bench for cpu_fetch_decode: directed programs, expected events queued, monitor compares.
module tb_cpu_fetch_decode;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] reg_a, alu_result;
  logic [7:0] pc, rf_wdata;
  logic [3:0] rs, rt, rd;
  logic [2:0] alu_op;
  logic       rf_we, rf_oe, halted, fault, illegal;
  logic [7:0] mem [256];
  logic       ack_en, force_ack;

  always #5 clk = ~clk;

  cpu_fetch_decode_if bus ();

  assign bus.mem_ack   = force_ack | (bus.mem_req & ack_en);
  assign bus.mem_rdata = mem[bus.mem_addr];

  cpu_fetch_decode #(.RESET_PC(8'h00), .WAIT_LIMIT(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .reg_a(reg_a), .alu_result(alu_result),
    .pc(pc), .rs(rs), .rt(rt), .rd(rd), .alu_op(alu_op), .rf_we(rf_we),
    .rf_oe(rf_oe), .rf_wdata(rf_wdata), .halted(halted), .fault(fault),
    .illegal(illegal)
  );

  typedef enum int {EV_FETCH, EV_WRITE, EV_ILL, EV_HALT} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int pc, rd, wdata, rs, rt, op, fault, lat;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0, failures = 0;
  int  cyc = 0, fetch_cyc = 0;
  logic prev_req = 1'b0, prev_halt = 1'b0, prev_we = 1'b0, prev_ill = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push(input ev_kind_t k, input int p, input int d, input int w,
                      input int s, input int t, input int o, input int f, input int l);
    ev_t e;
    e.kind = k; e.pc = p; e.rd = d; e.wdata = w; e.rs = s; e.rt = t;
    e.op = o; e.fault = f; e.lat = l;
    exp_q.push_back(e);
  endtask

  task automatic handle(input ev_kind_t k);
    ev_t e;
    int  lat;
    if (exp_q.size() == 0) begin
      chk("unexpected_event", int'(k), -1);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", int'(k), int'(e.kind));
    if (k != e.kind) return;
    lat = cyc - fetch_cyc;
    case (k)
      EV_FETCH: begin
        chk("fetch_pc", int'(pc), e.pc);
        if (e.lat > 0) chk("fetch_latency", lat, e.lat);
        if (e.rs >= 0) chk("fetch_rs_held", int'(rs), e.rs);
        fetch_cyc = cyc;
      end
      EV_WRITE: begin
        chk("wb_rd", int'(rd), e.rd);
        chk("wb_wdata", int'(rf_wdata), e.wdata);
        chk("wb_rs", int'(rs), e.rs);
        chk("wb_rt", int'(rt), e.rt);
        chk("wb_alu_op", int'(alu_op), e.op);
        chk("wb_pc", int'(pc), e.pc);
        chk("wb_oe_low", int'(rf_oe), 0);
        chk("wb_latency", lat, 4);
      end
      EV_ILL:  chk("illegal_latency", lat, 2);
      EV_HALT: begin
        chk("halt_fault", int'(fault), e.fault);
        chk("halt_pc", int'(pc), e.pc);
        chk("halt_latency", lat, e.lat);
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (bus.mem_req && !prev_req) handle(EV_FETCH);
      if (rf_we) begin
        chk("we_single_cycle", int'(prev_we), 0);
        handle(EV_WRITE);
      end
      if (illegal) begin
        chk("illegal_single_cycle", int'(prev_ill), 0);
        handle(EV_ILL);
      end
      if (halted && !prev_halt) handle(EV_HALT);
    end
    prev_req  = bus.mem_req;
    prev_halt = halted;
    prev_we   = rf_we;
    prev_ill  = illegal;
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic reset_assert();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_release();
    push(EV_FETCH, 0, -1, -1, -1, -1, -1, -1, 0);
    #1 rst = 1'b1;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", int'(halted), 1);
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int found;
    ack_en = 1'b1; force_ack = 1'b0;
    reg_a = 8'h00; alu_result = 8'h7F;

    // Segment A: LDI, ADD, taken BEQZ, HALT; reset hit mid FETCH_LO
    clear_mem();
    mem[8'h00] = 8'h63; mem[8'h01] = 8'h5A;
    mem[8'h02] = 8'h11; mem[8'h03] = 8'h23;
    mem[8'h04] = 8'h94; mem[8'h05] = 8'h40;
    mem[8'h40] = 8'hF0; mem[8'h41] = 8'h00;
    reset_assert();
    reset_release();
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (bus.mem_req && pc == 8'h01) found = 1;
    end
    chk("reach_fetch_lo", found, 1);
    force_ack = 1'b1;
    reset_assert();
    chk("rst_mem_req", int'(bus.mem_req), 0);
    chk("rst_pc", int'(pc), 0);
    chk("rst_rf_we", int'(rf_we), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_rd", int'(rd), 0);
    force_ack = 1'b0;
    reset_release();
    push(EV_WRITE, 8'h02, 3, 8'h5A, 5, 4'hA, 6, -1, -1);
    push(EV_FETCH, 8'h02, -1, -1, -1, -1, -1, -1, 5);
    push(EV_WRITE, 8'h04, 1, 8'h7F, 2, 3, 1, -1, -1);
    push(EV_FETCH, 8'h04, -1, -1, -1, -1, -1, -1, 5);
    push(EV_FETCH, 8'h40, -1, -1, 4, -1, -1, -1, 4);
    push(EV_HALT, 8'h42, -1, -1, -1, -1, -1, 0, 4);
    wait_halt(100);
    repeat (5) @(negedge clk);
    chk("halt_stays", int'(halted), 1);
    chk("halt_mem_req", int'(bus.mem_req), 0);
    chk("halt_pc_frozen", int'(pc), 8'h42);
    drain();

    // Segment B: untaken BEQZ, JMP, illegal opcode, NOP wrap at 0xFE, HALT
    reset_assert();
    clear_mem();
    mem[8'h00] = 8'h95; mem[8'h01] = 8'h30;
    mem[8'h02] = 8'h80; mem[8'h03] = 8'h10;
    mem[8'h10] = 8'hA0; mem[8'h11] = 8'h00;
    mem[8'h12] = 8'h80; mem[8'h13] = 8'hFE;
    reg_a = 8'h01;
    reset_release();
    push(EV_FETCH, 8'h02, -1, -1, 5, -1, -1, -1, 4);
    push(EV_FETCH, 8'h10, -1, -1, -1, -1, -1, -1, 4);
    push(EV_ILL, -1, -1, -1, -1, -1, -1, -1, 2);
    push(EV_FETCH, 8'h12, -1, -1, -1, -1, -1, -1, 4);
    push(EV_FETCH, 8'hFE, -1, -1, -1, -1, -1, -1, 4);
    push(EV_FETCH, 8'h00, -1, -1, -1, -1, -1, -1, 4);
    push(EV_HALT, 8'h02, -1, -1, -1, -1, -1, 0, 4);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (pc == 8'h10) found = 1;
    end
    chk("reach_jump_target", found, 1);
    mem[8'h00] = 8'hF0; mem[8'h01] = 8'h00;
    wait_halt(100);
    drain();

    // Segment C: memory never acknowledges -> fetch timeout
    reset_assert();
    ack_en = 1'b0;
    reset_release();
    push(EV_HALT, 8'h00, -1, -1, -1, -1, -1, 1, 15);
    wait_halt(60);
    force_ack = 1'b1;
    repeat (5) @(negedge clk);
    chk("timeout_halted", int'(halted), 1);
    chk("timeout_fault", int'(fault), 1);
    chk("timeout_mem_req", int'(bus.mem_req), 0);
    chk("timeout_ack_ignored_pc", int'(pc), 0);
    force_ack = 1'b0;
    drain();
    reset_assert();
    chk("fault_cleared", int'(fault), 0);
    chk("halt_cleared", int'(halted), 0);
    chk("req_low_in_reset", int'(bus.mem_req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
